// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// One request is accepted when imem_req and imem_ready are both high; the response follows later.
interface if_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with integrated IF/ID register: one outstanding fetch at a time,
// a one-entry skid buffer for responses arriving during an ID stall, and EX redirect handling.
module if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcwrite,
  input  logic            ifidwrite,
  input  logic            branch_taken_ex,
  input  logic [XLEN-1:0] branch_target_ex,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] pc_id,
  output logic [31:0]     instr_id,
  output logic            valid_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic            drop;
  logic            drop_nxt;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_pc_nxt;
  logic [31:0]     buf_instr;
  logic [31:0]     buf_instr_nxt;
  logic [XLEN-1:0] pc_id_nxt;
  logic [31:0]     instr_id_nxt;
  logic            valid_id_nxt;
  logic            req;
  logic            accept;

  // A redirect suppresses the request in the same cycle so the stale PC is never accepted.
  assign req            = (state == S_FETCH) & pcwrite & ~branch_taken_ex;
  assign accept         = req & imem.imem_ready;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // Next-state, PC, skid-buffer and IF/ID update logic.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    fetch_pc_nxt  = fetch_pc;
    drop_nxt      = drop;
    buf_pc_nxt    = buf_pc;
    buf_instr_nxt = buf_instr;
    pc_id_nxt     = pc_id;
    instr_id_nxt  = instr_id;
    valid_id_nxt  = valid_id;

    // With ID advancing and nothing new to hand over, IF/ID takes a bubble.
    if (ifidwrite) begin
      valid_id_nxt = 1'b0;
      instr_id_nxt = NOP;
    end else begin
      valid_id_nxt = valid_id;
      instr_id_nxt = instr_id;
    end

    if (branch_taken_ex) begin
      pc_nxt       = branch_target_ex;
      valid_id_nxt = 1'b0;
      instr_id_nxt = NOP;
      // The skid buffer is abandoned simply by leaving HOLD; its contents are never read again.
      if ((state == S_WAIT) && !imem.imem_rvalid) begin
        drop_nxt  = 1'b1;
        state_nxt = S_WAIT;
      end else begin
        drop_nxt  = 1'b0;
        state_nxt = S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (accept) begin
            fetch_pc_nxt = pc;
            pc_nxt       = pc + PC_STEP;
            state_nxt    = S_WAIT;
          end else begin
            state_nxt = S_FETCH;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = S_FETCH;
            end else if (ifidwrite) begin
              pc_id_nxt    = fetch_pc;
              instr_id_nxt = imem.imem_rdata;
              valid_id_nxt = 1'b1;
              state_nxt    = S_FETCH;
            end else begin
              buf_pc_nxt    = fetch_pc;
              buf_instr_nxt = imem.imem_rdata;
              state_nxt     = S_HOLD;
            end
          end else begin
            state_nxt = S_WAIT;
          end
        end
        S_HOLD: begin
          if (ifidwrite) begin
            pc_id_nxt    = buf_pc;
            instr_id_nxt = buf_instr;
            valid_id_nxt = 1'b1;
            state_nxt    = S_FETCH;
          end else begin
            state_nxt = S_HOLD;
          end
        end
        default: begin
          drop_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      fetch_pc  <= RESET_PC;
      drop      <= 1'b0;
      buf_pc    <= {XLEN{1'b0}};
      buf_instr <= 32'h0000_0000;
      pc_id     <= {XLEN{1'b0}};
      instr_id  <= NOP;
      valid_id  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      fetch_pc  <= fetch_pc_nxt;
      drop      <= drop_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_instr <= buf_instr_nxt;
      pc_id     <= pc_id_nxt;
      instr_id  <= instr_id_nxt;
      valid_id  <= valid_id_nxt;
    end
  end

endmodule
